movz_seq_encoder: RTL and testbench
===================================

# movz_seq_encoder

Constant-materialisation encoder: accepts a 64-bit constant and destination register, emits the LEGv8 instruction sequence (ADDI, or MOVZ followed by MOVK) that loads that constant. It is the encode-side counterpart of the datapath's immediate extension for I-type and MOVZ/MOVK fields. It sits between the test-program generator / boot loader and instruction memory, producing one 32-bit instruction word per output handshake.

## Interface
- USE_ADDI, default 1: constants below 4096 are emitted as a single `ADDI Rd, XZR, #imm`; 0 disables this, so MOVZ/MOVK is always used.
- CLK  in  1  single clock, rising-edge.
- resetl  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle, request accepted on `in_valid & in_ready`.
- Value  in  64  constant to materialise.
- Rd  in  5  destination register.
- out_valid  out  1  Instr valid.
- out_ready  in  1  consumer accepts Instr.
- Instr  out  32  encoded instruction word.
- out_last  out  1  Instr is final word of the sequence.
- busy  out  1  sequence in progress (state EMIT).

## Operation
- Encodings:
  - ADDI: [31:22]=10'b1001000100, [21:10]=imm12, [9:5]=5'd31, [4:0]=Rd.
  - MOVZ: [31:23]=9'b110100101. MOVK: [31:23]=9'b111100101.
  - MOVZ/MOVK fields: [22:21]=hw, [20:5]=Value[16*hw+15:16*hw], [4:0]=Rd.
- On accept, latch Value and Rd, and build a 4-bit nonzero-halfword mask.
- ADDI path: USE_ADDI=1 and Value<4096 (including 0). Emit one ADDI with out_last=1.
- MOVZ path, all other cases:
  - First word is MOVZ at the lowest set mask bit. If the mask is empty (Value=0, USE_ADDI=0), emit MOVZ hw=0 imm=0.
  - Clear that bit, then emit a MOVK for each remaining set bit in ascending hw order.
  - out_last accompanies the word whose remaining mask is empty.
  - Sequence length is 1–4 words.
- FSM has two states:
  - IDLE: in_ready=1. On accept, load the first word and go to EMIT.
  - EMIT: out_valid=1. On `out_valid & out_ready` with out_last=1, go to IDLE. Otherwise load the next word and stay in EMIT.
- in_valid while in EMIT is ignored; the Value and Rd inputs are don't-care.

## Timing
- Reset values: out_valid=0, Instr=0, out_last=0, busy=0, in_ready=1, state IDLE, latched registers 0.
- Latency: first word is valid the cycle after accept (registered output).
- Throughput: one word per cycle while out_ready=1. The next word loads on the same edge as the transfer, with no bubbles.
- Stall: while `out_valid & !out_ready`, Instr and out_last are held stable.
- After the final transfer, in_ready is 1 in the next cycle. There is no same-cycle re-accept, so the minimum request-to-request spacing is N+1 cycles for an N-word sequence.
- resetl asserted mid-sequence: all outputs take reset values immediately (asynchronous) and the partial sequence is discarded. After release the block is in IDLE.

## Structure
- Shared package: MOVZ/MOVK/ADDI opcode constants, field bit positions, XZR=31, IMM12_MAX=4095, and the state enum.
- Sub-module `hw_pick`: combinational lowest-set-bit picker, taking a 4-bit mask and returning a 2-bit index and a found flag. It is used for both the first and subsequent words.

## Test plan
- Value=0xABC, Rd=3, USE_ADDI=1 -> single Instr 0x912AF3E3, out_last=1, in_ready high the cycle after the transfer.
- Value=0x1234_0000_0000_5678, Rd=9 -> 0xD28ACF09 (MOVZ hw0), then 0xF2E24689 (MOVK hw3) with out_last=1, on consecutive cycles.
- Value=0x0000_0001_0000_0000, Rd=0 -> single 0xD2C00020 (MOVZ hw2 imm 1), out_last=1.
- Value=0xFFFF_FFFF_FFFF_FFFF, Rd=1, out_ready low 3 cycles during the 2nd word -> four words hw0..hw3. The 2nd word is held stable through the stall. out_last only on the 4th.
- USE_ADDI=0, Value=0, Rd=5 -> single 0xD2800005. in_valid pulsed during EMIT of any sequence is not accepted.
- resetl pulsed low during the 2nd word of a 3-word sequence -> out_valid=0 asynchronously. After release, a new request Value=0x5 (USE_ADDI=1), Rd=2 yields 0x910017E2 only.

Source files
------------

// File: rtl/movz_seq_encoder_pkg.sv
// movz_seq_encoder_pkg: LEGv8 opcodes, field positions and FSM states for the constant encoder
package movz_seq_encoder_pkg;
  localparam logic [9:0] ADDI_OP = 10'b1001000100;
  localparam logic [8:0] MOVZ_OP = 9'b110100101;
  localparam logic [8:0] MOVK_OP = 9'b111100101;
  localparam int ADDI_OPC_LSB = 22;
  localparam int MOV_OPC_LSB = 23;
  localparam int HW_LSB = 21;
  localparam int IMM12_LSB = 10;
  localparam int IMM16_LSB = 5;
  localparam int RN_LSB = 5;
  localparam logic [4:0] XZR = 5'd31;
  localparam int IMM12_MAX = 4095;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic logic [31:0] enc_mov(input logic [8:0] op, input logic [1:0] hw,
                                          input logic [15:0] imm, input logic [4:0] rd);
    return (32'(op) << MOV_OPC_LSB) | (32'(hw) << HW_LSB) | (32'(imm) << IMM16_LSB) | 32'(rd);
  endfunction
  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rd);
    return (32'(ADDI_OP) << ADDI_OPC_LSB) | (32'(imm) << IMM12_LSB) | (32'(XZR) << RN_LSB) | 32'(rd);
  endfunction
endpackage

// File: rtl/movz_seq_encoder_hw_pick.sv
// hw_pick: lowest-set-bit picker over the 4-bit nonzero-halfword mask
module hw_pick (
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       found
);
  always_comb begin
    found = |mask;
    idx = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : mask[3] ? 2'd3 : 2'd0;
  end
endmodule

// File: rtl/movz_seq_encoder.sv
// movz_seq_encoder: emits the ADDI or MOVZ/MOVK sequence that loads a 64-bit constant into Rd
module movz_seq_encoder
  import movz_seq_encoder_pkg::*;
#(
  parameter int USE_ADDI = 1
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] Value,
  input  logic [4:0]  Rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Instr,
  output logic        out_last,
  output logic        busy
);
  state_t state, state_nx;
  logic [63:0] val, src_val;
  logic [4:0] rd, src_rd;
  logic [3:0] mask, pick_mask, rem;
  logic [1:0] idx;
  logic found, accept, advance, use_addi;
  logic [15:0] imm;
  logic [31:0] word;
  hw_pick u_pick (.mask(pick_mask), .idx(idx), .found(found));
  // In IDLE the picker looks at the incoming request; in EMIT at the remaining latched mask
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == EMIT;
    busy = out_valid;
    accept = in_valid & in_ready;
    advance = out_valid & out_ready & ~out_last;
    src_val = in_ready ? Value : val;
    src_rd = in_ready ? Rd : rd;
    pick_mask = in_ready ? {|Value[63:48], |Value[47:32], |Value[31:16], |Value[15:0]} : mask;
    rem = pick_mask & ~(4'b0001 << idx);
    imm = found ? src_val[{idx, 4'd0} +: 16] : 16'd0;
    use_addi = (USE_ADDI != 0) & in_ready & (Value <= 64'(IMM12_MAX));
    word = use_addi ? enc_addi(Value[11:0], src_rd) : enc_mov(in_ready ? MOVZ_OP : MOVK_OP, idx, imm, src_rd);
    state_nx = accept ? EMIT : (out_valid & out_ready & out_last) ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge resetl)
    if (!resetl) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge resetl)
    if (!resetl) begin
      val <= '0;
      rd <= '0;
      mask <= '0;
      Instr <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept) begin
        val <= Value;
        rd <= Rd;
      end
      if (accept | advance) begin
        Instr <= word;
        out_last <= use_addi | (rem == 4'd0);
        mask <= rem;
      end
    end
endmodule

// File: tb/tb_movz_seq_encoder.sv
// tb_movz_seq_encoder: directed checks of ADDI/MOVZ/MOVK sequences, stalls, EMIT-time requests and async reset
module tb_movz_seq_encoder;
  logic CLK = 1'b0;
  logic resetl = 1'b0;
  logic in_valid = 1'b0, in_valid_b = 1'b0, out_ready = 1'b1;
  logic [63:0] Value = '0;
  logic [4:0] Rd = '0;
  logic a_in_ready, a_out_valid, a_last, a_busy;
  logic b_in_ready, b_out_valid, b_last, b_busy;
  logic [31:0] a_instr, b_instr;
  int n_checks = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  movz_seq_encoder #(.USE_ADDI(1)) dut_a (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(a_in_ready), .Value(Value), .Rd(Rd),
    .out_valid(a_out_valid), .out_ready(out_ready), .Instr(a_instr), .out_last(a_last), .busy(a_busy));
  movz_seq_encoder #(.USE_ADDI(0)) dut_b (
    .CLK(CLK), .resetl(resetl), .in_valid(in_valid_b), .in_ready(b_in_ready), .Value(Value), .Rd(Rd),
    .out_valid(b_out_valid), .out_ready(out_ready), .Instr(b_instr), .out_last(b_last), .busy(b_busy));

  task automatic send_a(input logic [63:0] v, input logic [4:0] r);
    @(negedge CLK);
    Value = v; Rd = r; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] v, input logic [4:0] r);
    @(negedge CLK);
    Value = v; Rd = r; in_valid_b = 1'b1;
    @(posedge CLK);
    #1 in_valid_b = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({a_out_valid, a_instr, a_last, a_busy, a_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got v=%b i=%h l=%b b=%b r=%b", a_out_valid, a_instr, a_last, a_busy, a_in_ready);
    end
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
  endtask

  task automatic test_addi;
    send_a(64'hABC, 5'd3);
    @(negedge CLK);
    n_checks++;
    if ({a_out_valid, a_instr, a_last, a_busy} !== {1'b1, 32'h912AF3E3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_word got v=%b i=%h l=%b b=%b exp 1 912af3e3 1 1", a_out_valid, a_instr, a_last, a_busy);
    end
    @(negedge CLK);
    n_checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL addi_idle got rdy=%b v=%b exp 1 0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_movz;
    logic [63:0] vals [3] = '{64'h1234_0000_0000_5678, 64'h0000_0001_0000_0000, 64'h0000_0003_0002_0001};
    logic [4:0] rds [3] = '{5'd9, 5'd0, 5'd4};
    int lens [3] = '{2, 1, 3};
    logic [31:0] exp [3][3] = '{'{32'hD28ACF09, 32'hF2E24689, 32'h0},
                                '{32'hD2C00020, 32'h0, 32'h0},
                                '{32'hD2800024, 32'hF2A00044, 32'hF2C00064}};
    for (int t = 0; t < 3; t++) begin
      send_a(vals[t], rds[t]);
      for (int i = 0; i < lens[t]; i++) begin
        @(negedge CLK);
        n_checks++;
        if ({a_out_valid, a_instr, a_last} !== {1'b1, exp[t][i], i == lens[t] - 1}) begin
          n_fail++;
          $display("FAIL movz_seq[%0d][%0d] got v=%b i=%h l=%b exp i=%h l=%b", t, i, a_out_valid, a_instr, a_last,
                   exp[t][i], i == lens[t] - 1);
        end
      end
      @(negedge CLK);
      n_checks++;
      if ({a_in_ready, a_out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL movz_idle[%0d] got rdy=%b v=%b", t, a_in_ready, a_out_valid);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] exp [4] = '{32'hD29FFFE1, 32'hF2BFFFE1, 32'hF2DFFFE1, 32'hF2FFFFE1};
    send_a(64'hFFFF_FFFF_FFFF_FFFF, 5'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({a_out_valid, a_instr, a_last} !== {1'b1, exp[i], i == 3}) begin
        n_fail++;
        $display("FAIL stall_seq[%0d] got v=%b i=%h l=%b exp %h", i, a_out_valid, a_instr, a_last, exp[i]);
      end
      if (i == 1) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          n_checks++;
          if ({a_out_valid, a_instr, a_last} !== {1'b1, exp[1], 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold got v=%b i=%h l=%b exp %h", a_out_valid, a_instr, a_last, exp[1]);
          end
        end
        out_ready = 1'b1;
      end
    end
    @(negedge CLK);
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_idle got rdy=%b", a_in_ready);
    end
  endtask

  task automatic test_no_addi;
    send_b(64'h0, 5'd5);
    @(negedge CLK);
    n_checks++;
    if ({b_out_valid, b_instr, b_last} !== {1'b1, 32'hD2800005, 1'b1}) begin
      n_fail++;
      $display("FAIL noaddi_zero got v=%b i=%h l=%b exp d2800005", b_out_valid, b_instr, b_last);
    end
    Value = 64'hFFFF; Rd = 5'd7; in_valid_b = 1'b1;
    @(posedge CLK);
    #1 in_valid_b = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({b_out_valid, b_in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL emit_ignore got v=%b rdy=%b exp 0 1", b_out_valid, b_in_ready);
    end
    send_b(64'hABC, 5'd3);
    @(negedge CLK);
    n_checks++;
    if ({b_out_valid, b_instr, b_last} !== {1'b1, 32'hD2815783, 1'b1}) begin
      n_fail++;
      $display("FAIL noaddi_small got v=%b i=%h l=%b exp d2815783", b_out_valid, b_instr, b_last);
    end
    @(negedge CLK);
  endtask

  task automatic test_async_reset;
    send_a(64'h0000_0003_0002_0001, 5'd4);
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (a_instr !== 32'hF2A00044) begin
      n_fail++;
      $display("FAIL rst_pre got i=%h exp f2a00044", a_instr);
    end
    #2 resetl = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_instr, a_last, a_busy, a_in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_async got v=%b i=%h l=%b b=%b r=%b", a_out_valid, a_instr, a_last, a_busy, a_in_ready);
    end
    @(negedge CLK);
    resetl = 1'b1;
    send_a(64'h5, 5'd2);
    @(negedge CLK);
    n_checks++;
    if ({a_out_valid, a_instr, a_last} !== {1'b1, 32'h910017E2, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_after got v=%b i=%h l=%b exp 910017e2", a_out_valid, a_instr, a_last);
    end
    @(negedge CLK);
    n_checks++;
    if (a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after_idle got v=%b exp 0", a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_movz();
    test_stall();
    test_no_addi();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
